// File: rtl/dvp_stream_capture.sv
// -----------------------------------------------------------------------------
// dvp_stream_capture
//   Captures a DVP-style camera bus (vsync / href / byte data) into pixels,
//   buffers them in a small FIFO and emits AXI4-Stream for a VDMA S2MM channel.
//   tuser marks the first pixel of a frame, tlast marks pixel H_SIZE-1 of a line.
//   Capture is armed only at frame boundaries. A FIFO overflow drops the rest
//   of the frame. Line-length, frame-size and overflow errors are sticky.
//   Everything runs on the rising edge of pclk. Reset is resetn: synchronous,
//   active-low.
//
// Optional feature macro: CAPTURE_STATS_EN
//   defined   -> frame_count / drop_count are live 16-bit wrapping counters
//   undefined -> both ports are tied to 0 and the counter logic is absent
//
// Ports
//   pclk, resetn         clock, synchronous active-low reset
//   vsync, href, data    camera bus
//   ctrl_enable          capture enable, sampled only at frame start
//   err_clear            pulse, clears the sticky error flags
//   fsync                one-cycle frame-start pulse
//   m_axis_*             AXI4-Stream master (tdata zero-extended, first byte MSB)
//   busy                 state is ACTIVE or DROP
//   err_*                sticky error flags
//   frame_count          frames delivered without error
//   drop_count           frames dropped on overflow
// -----------------------------------------------------------------------------
module dvp_stream_capture #(
  parameter int H_SIZE        = 640,
  parameter int V_SIZE        = 480,
  parameter int DATA_W        = 8,
  parameter int BYTES_PER_PIX = 2,
  parameter int TDATA_W       = 32,
  parameter int FIFO_DEPTH    = 16,
  parameter int VSYNC_POL     = 1
) (
  input  logic               pclk,
  input  logic               resetn,
  input  logic               vsync,
  input  logic               href,
  input  logic [DATA_W-1:0]  data,
  input  logic               ctrl_enable,
  input  logic               err_clear,
  output logic               fsync,
  output logic               m_axis_tvalid,
  input  logic               m_axis_tready,
  output logic [TDATA_W-1:0] m_axis_tdata,
  output logic               m_axis_tuser,
  output logic               m_axis_tlast,
  output logic               busy,
  output logic               err_overflow,
  output logic               err_short_line,
  output logic               err_long_line,
  output logic               err_frame_size,
  output logic [15:0]        frame_count,
  output logic [15:0]        drop_count
);

  localparam int PIX_W      = DATA_W * BYTES_PER_PIX;
  localparam int BEAT_W     = (BYTES_PER_PIX > 1) ? $clog2(BYTES_PER_PIX) : 1;
  localparam int PIX_CNT_W  = $clog2(H_SIZE + 1);
  localparam int LINE_CNT_W = $clog2(V_SIZE + 2);
  localparam int AW         = $clog2(FIFO_DEPTH);
  localparam int ENTRY_W    = PIX_W + 2;

  localparam logic [BEAT_W-1:0]     LAST_BEAT = BEAT_W'(BYTES_PER_PIX - 1);
  localparam logic [PIX_CNT_W-1:0]  H_MAX     = PIX_CNT_W'(H_SIZE);
  localparam logic [PIX_CNT_W-1:0]  H_LAST    = PIX_CNT_W'(H_SIZE - 1);
  localparam logic [LINE_CNT_W-1:0] V_LINES   = LINE_CNT_W'(V_SIZE);
  localparam logic [LINE_CNT_W-1:0] V_SAT     = LINE_CNT_W'(V_SIZE + 1);
  localparam logic [AW:0]           DEPTH     = (AW + 1)'(FIFO_DEPTH);
  localparam logic                  BLANK_LVL = (VSYNC_POL != 0);

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DROP} state_t;

  state_t                r_state, w_state_next;
  logic                  w_fsync_next;
  logic                  r_fsync;
  logic                  r_vs_blank_d, r_href_d;
  logic [BEAT_W-1:0]     r_beat;
  logic [PIX_CNT_W-1:0]  r_pix;
  logic [LINE_CNT_W-1:0] r_line;
  logic [PIX_W-1:0]      r_acc;
  logic                  r_err_overflow, r_err_short, r_err_long, r_err_frame;

  // FIFO: r_count includes the entry currently presented on the output register
  logic [ENTRY_W-1:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0]         r_wr_ptr, r_rd_ptr;
  logic [AW:0]           r_count;
  logic                  r_out_valid;
  logic [ENTRY_W-1:0]    r_out_entry;

  // Edge detection on the camera sync lines
  logic w_vs_blank, w_frame_start, w_frame_end, w_href_rise, w_href_fall;
  assign w_vs_blank    = (vsync == BLANK_LVL);
  assign w_frame_start = r_vs_blank_d & ~w_vs_blank;
  assign w_frame_end   = ~r_vs_blank_d & w_vs_blank;
  assign w_href_rise   = href & ~r_href_d;
  assign w_href_fall   = ~href & r_href_d;

  // Byte assembly: the href rising edge restarts both beat and pixel counters
  // on the same cycle that carries beat 0 of the line.
  logic                 w_active, w_capture, w_pix_done, w_in_range;
  logic [BEAT_W-1:0]    w_beat;
  logic [PIX_CNT_W-1:0] w_pix;
  logic [PIX_W-1:0]     w_acc_next;
  assign w_active   = (r_state == S_ACTIVE);
  assign w_capture  = w_active & href & ~w_vs_blank;
  assign w_beat     = w_href_rise ? '0 : r_beat;
  assign w_pix      = w_href_rise ? '0 : r_pix;
  assign w_acc_next = (r_acc << DATA_W) | PIX_W'(data);
  assign w_pix_done = w_capture & (w_beat == LAST_BEAT);
  assign w_in_range = (w_pix != H_MAX);

  // FIFO handshake; a push into a full FIFO is legal when the same edge pops
  logic               w_pop, w_push, w_full;
  logic               w_overflow, w_long, w_short;
  logic [AW:0]        w_count_after_pop;
  logic [AW-1:0]      w_rd_ptr_next;
  logic [ENTRY_W-1:0] w_entry;
  assign w_pop             = r_out_valid & m_axis_tready;
  assign w_full            = (r_count == DEPTH);
  assign w_overflow        = w_pix_done & w_in_range & w_full & ~w_pop;
  assign w_push            = w_pix_done & w_in_range & ~w_overflow;
  assign w_long            = w_pix_done & ~w_in_range;
  assign w_short           = w_active & w_href_fall & (r_pix != '0) & (r_pix != H_MAX);
  assign w_count_after_pop = r_count - (AW + 1)'(w_pop);
  assign w_rd_ptr_next     = r_rd_ptr + AW'(w_pop);
  assign w_entry           = {(r_line == '0) && (w_pix == '0), (w_pix == H_LAST), w_acc_next};

  // Line counting saturates just past V_SIZE so the frame-size check stays exact
  logic                  w_line_inc, w_frame_size_err;
  logic [LINE_CNT_W-1:0] w_line_next;
  assign w_line_inc       = w_active & w_href_fall;
  assign w_line_next      = (w_line_inc && r_line != V_SAT) ? r_line + LINE_CNT_W'(1) : r_line;
  assign w_frame_size_err = w_active & w_frame_end & (w_line_next != V_LINES);

  // NOTE: every signal driven here gets a default first, so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_fsync_next = 1'b0;
    unique case (r_state)
      S_IDLE: if (w_frame_start && ctrl_enable) begin
        w_state_next = S_ACTIVE;
        w_fsync_next = 1'b1;
      end
      S_ACTIVE: begin
        if (w_frame_end)     w_state_next = S_IDLE;
        else if (w_overflow) w_state_next = S_DROP;
      end
      S_DROP: if (w_frame_end) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // NOTE: all sequential state uses non-blocking assignment so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge pclk) begin
    if (!resetn) begin
      r_state        <= S_IDLE;
      r_fsync        <= 1'b0;
      r_vs_blank_d   <= 1'b0;  // "not blank": capture waits for a fresh blank->active
      r_href_d       <= 1'b0;
      r_beat         <= '0;
      r_pix          <= '0;
      r_line         <= '0;
      r_acc          <= '0;
      r_err_overflow <= 1'b0;
      r_err_short    <= 1'b0;
      r_err_long     <= 1'b0;
      r_err_frame    <= 1'b0;
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_count        <= '0;
      r_out_valid    <= 1'b0;
      r_out_entry    <= '0;
    end else begin
      r_state      <= w_state_next;
      r_fsync      <= w_fsync_next;
      r_vs_blank_d <= w_vs_blank;
      r_href_d     <= href;

      if (w_vs_blank)     r_beat <= '0;
      else if (w_capture) r_beat <= w_pix_done ? '0 : w_beat + BEAT_W'(1);
      if (w_capture)      r_acc  <= w_acc_next;

      if (w_fsync_next)                   r_pix <= '0;
      else if (w_pix_done && w_in_range)  r_pix <= w_pix + PIX_CNT_W'(1);
      else                                r_pix <= w_pix;
      r_line <= w_fsync_next ? '0 : w_line_next;

      // An error event wins over a coincident clear
      r_err_overflow <= (r_err_overflow & ~err_clear) | w_overflow;
      r_err_short    <= (r_err_short    & ~err_clear) | w_short;
      r_err_long     <= (r_err_long     & ~err_clear) | w_long;
      r_err_frame    <= (r_err_frame    & ~err_clear) | w_frame_size_err;

      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      r_rd_ptr <= w_rd_ptr_next;
      r_count  <= w_count_after_pop + (AW + 1)'(w_push);

      // Output register shows the head entry once it has been in memory for
      // one edge; while stalled it reloads the same, unchanged entry.
      if (w_count_after_pop != '0) begin
        r_out_valid <= 1'b1;
        r_out_entry <= r_mem[w_rd_ptr_next];
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

  // NOTE: the storage array is not reset; r_count alone decides which entries
  // are meaningful, so the memory can map onto plain RAM.
  always_ff @(posedge pclk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_entry;
  end

`ifdef CAPTURE_STATS_EN
  logic        r_frame_err;
  logic        w_any_err, w_frame_ok;
  logic [15:0] r_frame_count, r_drop_count;
  assign w_any_err  = w_overflow | w_short | w_long;
  assign w_frame_ok = w_active & w_frame_end & ~r_frame_err & ~w_any_err & ~w_frame_size_err;

  always_ff @(posedge pclk) begin
    if (!resetn) begin
      r_frame_err   <= 1'b0;
      r_frame_count <= '0;
      r_drop_count  <= '0;
    end else begin
      r_frame_err <= w_fsync_next ? 1'b0 : (r_frame_err | w_any_err);
      if (w_frame_ok) r_frame_count <= r_frame_count + 16'd1;
      if (w_overflow) r_drop_count  <= r_drop_count + 16'd1;
    end
  end

  assign frame_count = r_frame_count;
  assign drop_count  = r_drop_count;
`else
  assign frame_count = '0;
  assign drop_count  = '0;
`endif

  assign fsync          = r_fsync;
  assign busy           = (r_state != S_IDLE);
  assign m_axis_tvalid  = r_out_valid;
  assign m_axis_tuser   = r_out_entry[ENTRY_W-1];
  assign m_axis_tlast   = r_out_entry[ENTRY_W-2];
  assign m_axis_tdata   = TDATA_W'(r_out_entry[PIX_W-1:0]);
  assign err_overflow   = r_err_overflow;
  assign err_short_line = r_err_short;
  assign err_long_line  = r_err_long;
  assign err_frame_size = r_err_frame;

endmodule

// File: tb/tb_dvp_stream_capture.sv
// -----------------------------------------------------------------------------
// tb_dvp_stream_capture
//   Directed bench for dvp_stream_capture with a 4x2 RGB565 geometry and a
//   4-entry FIFO. Camera bytes follow 0x12, 0x34, 0x56, ... (step 0x22, wrapping
//   at 8 bits). A negedge monitor records every AXIS transfer and fsync pulse;
//   the stimulus thread compares those records with hand-derived expectations.
// -----------------------------------------------------------------------------
module tb_dvp_stream_capture;

  localparam int H     = 4;
  localparam int V     = 2;
  localparam int DEPTH = 4;

`ifdef CAPTURE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        pclk = 1'b0;
  logic        resetn, vsync, href, ctrl_enable, err_clear, m_axis_tready;
  logic [7:0]  data;
  logic        fsync, m_axis_tvalid, m_axis_tuser, m_axis_tlast, busy;
  logic [31:0] m_axis_tdata;
  logic        err_overflow, err_short_line, err_long_line, err_frame_size;
  logic [15:0] frame_count, drop_count;

  dvp_stream_capture #(
    .H_SIZE(H), .V_SIZE(V), .DATA_W(8), .BYTES_PER_PIX(2),
    .TDATA_W(32), .FIFO_DEPTH(DEPTH), .VSYNC_POL(1)
  ) dut (
    .pclk(pclk), .resetn(resetn), .vsync(vsync), .href(href), .data(data),
    .ctrl_enable(ctrl_enable), .err_clear(err_clear), .fsync(fsync),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tuser(m_axis_tuser),
    .m_axis_tlast(m_axis_tlast), .busy(busy), .err_overflow(err_overflow),
    .err_short_line(err_short_line), .err_long_line(err_long_line),
    .err_frame_size(err_frame_size), .frame_count(frame_count),
    .drop_count(drop_count)
  );

  always #5 pclk = ~pclk;

  typedef struct packed {
    logic [31:0] d;
    logic        u;
    logic        l;
  } beat_t;

  beat_t q[$];
  int    n_fsync = 0;
  int    checks = 0;
  int    failures = 0;
  int    bidx = 0;

  // Monitor: sample half a cycle away from the active edge
  always @(negedge pclk) begin
    if (resetn) begin
      if (m_axis_tvalid && m_axis_tready)
        q.push_back({m_axis_tdata, m_axis_tuser, m_axis_tlast});
      if (fsync) n_fsync++;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] byte_at(input int k);
    return 8'(32'h12 + 32'h22 * k);
  endfunction

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  function automatic logic [6:0] flags();
    return {m_axis_tvalid, busy, fsync, err_overflow, err_short_line,
            err_long_line, err_frame_size};
  endfunction

  task automatic frame_open();
    href  = 1'b0;
    vsync = 1'b1;
    repeat (4) tick();
    vsync = 1'b0;
    repeat (3) tick();
  endtask

  task automatic frame_close();
    href  = 1'b0;
    repeat (2) tick();
    vsync = 1'b1;
    repeat (4) tick();
  endtask

  // One line of npix pixels; err_clear / resetn can be pulsed on a chosen beat
  task automatic send_line(input int npix, input int clr_beat, input int rst_beat);
    for (int b = 0; b < 2 * npix; b++) begin
      href      = 1'b1;
      data      = byte_at(bidx);
      bidx++;
      err_clear = (b == clr_beat);
      resetn    = (b != rst_beat);
      tick();
      if (b == rst_beat) begin
        check("rst_flags",       64'(flags()),     64'h0);
        check("rst_frame_count", 64'(frame_count), 64'h0);
        check("rst_drop_count",  64'(drop_count),  64'h0);
      end
    end
    href      = 1'b0;
    err_clear = 1'b0;
    resetn    = 1'b1;
    data      = 8'h00;
    repeat (3) tick();
  endtask

  task automatic send_frame(input int n0, input int n1);
    frame_open();
    send_line(n0, -1, -1);
    send_line(n1, -1, -1);
    frame_close();
  endtask

  // Beats base..base+n-1 carry consecutive pixels starting at byte start_byte
  task automatic check_beats(input string tag, input int base, input int n,
                             input int start_byte, input int last_mask);
    check($sformatf("%s_count", tag), 64'(q.size() - base), 64'(n));
    for (int i = 0; i < n && base + i < q.size(); i++) begin
      logic [15:0] px;
      px = {byte_at(start_byte + 2 * i), byte_at(start_byte + 2 * i + 1)};
      check($sformatf("%s_data%0d", tag, i), 64'(q[base + i].d), 64'({16'h0, px}));
      check($sformatf("%s_user%0d", tag, i), 64'(q[base + i].u), 64'(i == 0));
      check($sformatf("%s_last%0d", tag, i), 64'(q[base + i].l), 64'(last_mask[i]));
    end
  endtask

  int base, fs_base, start, fc_exp;

  initial begin
    resetn = 1'b0; vsync = 1'b1; href = 1'b0; data = 8'h00;
    ctrl_enable = 1'b1; err_clear = 1'b0; m_axis_tready = 1'b1;
    repeat (3) tick();
    resetn = 1'b1;
    tick();

    // Reset state
    check("reset_flags",       64'(flags()),     64'h0);
    check("reset_frame_count", 64'(frame_count), 64'h0);
    check("reset_drop_count",  64'(drop_count),  64'h0);

    // T1: clean 4x2 frame, tlast on beats 4 and 8
    base = q.size(); fs_base = n_fsync; start = bidx;
    send_frame(4, 4);
    check("t1_fsync", 64'(n_fsync - fs_base), 64'd1);
    check_beats("t1", base, 8, start, 32'h88);
    if (q.size() > base) check("t1_first_tdata", 64'(q[base].d), 64'h0000_1234);
    check("t1_errors", 64'(flags()), 64'h0);
    fc_exp = STATS ? 1 : 0;
    check("t1_frame_count", 64'(frame_count), 64'(fc_exp));

    // T2: enable dropped mid-frame; this frame completes, the next is skipped
    base = q.size(); fs_base = n_fsync; start = bidx;
    frame_open();
    send_line(4, -1, -1);
    ctrl_enable = 1'b0;
    send_line(4, -1, -1);
    frame_close();
    check("t2_fsync", 64'(n_fsync - fs_base), 64'd1);
    check_beats("t2", base, 8, start, 32'h88);
    fc_exp = STATS ? 2 : 0;
    check("t2_frame_count", 64'(frame_count), 64'(fc_exp));
    base = q.size(); fs_base = n_fsync;
    send_frame(4, 4);
    check("t2_off_fsync", 64'(n_fsync - fs_base), 64'd0);
    check("t2_off_beats", 64'(q.size() - base), 64'd0);
    check("t2_off_frame_count", 64'(frame_count), 64'(fc_exp));
    ctrl_enable = 1'b1;

    // T3: stalled stream, overflow on the 5th pixel with a coincident err_clear
    m_axis_tready = 1'b0;
    base = q.size(); start = bidx;
    frame_open();
    send_line(4, -1, -1);
    send_line(4, 1, -1);
    frame_close();
    check("t3_overflow",    64'(err_overflow), 64'd1);
    check("t3_drop_count",  64'(drop_count),   64'(STATS ? 1 : 0));
    check("t3_frame_count", 64'(frame_count),  64'(fc_exp));
    check("t3_hold_valid",  64'(m_axis_tvalid), 64'd1);
    check("t3_hold_data",   64'(m_axis_tdata), 64'({16'h0, byte_at(start), byte_at(start + 1)}));
    check("t3_hold_user",   64'(m_axis_tuser), 64'd1);
    check("t3_stalled_beats", 64'(q.size() - base), 64'd0);
    m_axis_tready = 1'b1;
    repeat (8) tick();
    check_beats("t3_drain", base, DEPTH, start, 32'h8);
    check("t3_drained_valid", 64'(m_axis_tvalid), 64'd0);
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    check("t3_cleared", 64'(err_overflow), 64'd0);
    base = q.size(); start = bidx;
    send_frame(4, 4);
    check_beats("t3_next", base, 8, start, 32'h88);
    check("t3_next_errors", 64'(flags()), 64'h0);
    fc_exp = STATS ? 3 : 0;
    check("t3_next_frame_count", 64'(frame_count), 64'(fc_exp));

    // T4: 3-pixel line then 5-pixel line; the extra pixel is discarded
    base = q.size(); start = bidx;
    send_frame(3, 5);
    check_beats("t4", base, 7, start, 32'h40);
    check("t4_short", 64'(err_short_line), 64'd1);
    check("t4_long",  64'(err_long_line),  64'd1);
    check("t4_fsize", 64'(err_frame_size), 64'd0);
    check("t4_ovf",   64'(err_overflow),   64'd0);
    check("t4_frame_count", 64'(frame_count), 64'(fc_exp));

    // T5: reset mid-line with a word buffered and errors sticky
    m_axis_tready = 1'b0;
    frame_open();
    send_line(4, -1, 2);
    base = q.size(); fs_base = n_fsync;
    send_line(4, -1, -1);
    m_axis_tready = 1'b1;
    frame_close();
    repeat (4) tick();
    check("t5_no_beats", 64'(q.size() - base), 64'd0);
    check("t5_no_fsync", 64'(n_fsync - fs_base), 64'd0);
    check("t5_idle", 64'(flags()), 64'h0);
    base = q.size(); fs_base = n_fsync; start = bidx;
    send_frame(4, 4);
    check("t5_resume_fsync", 64'(n_fsync - fs_base), 64'd1);
    check_beats("t5_resume", base, 8, start, 32'h88);
    check("t5_frame_count", 64'(frame_count), 64'(STATS ? 1 : 0));
    check("t5_drop_count",  64'(drop_count),  64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dvp_stream_capture.md
Name: dvp_stream_capture

Overview:
- Parametrised successor to the fixed 640x480 RGB565 camera capture.
- Accepts a DVP-style camera bus (vsync/href/byte data) with configurable frame geometry and bytes per pixel.
- Assembles pixels and buffers them in an internal FIFO, then emits AXI4-Stream with SOF (tuser) and EOL (tlast) markers for the VDMA S2MM channel.
- Adds line-length and overflow error detection, whole-frame drop on overflow, and arming on frame boundaries only. Everything runs in the pclk domain.

Parameters:
- H_SIZE, 640: active pixels per line.
- V_SIZE, 480: active lines per frame.
- DATA_W, 8: camera data bus width (bits).
- BYTES_PER_PIX, 2: camera bus beats per pixel (1..4).
- TDATA_W, 32: AXIS data width; must be >= DATA_W*BYTES_PER_PIX.
- FIFO_DEPTH, 16: output FIFO entries; power of two, >= 4.
- VSYNC_POL, 1: 1 = vsync high during vertical blanking; 0 = inverted.

Ports:
- pclk  in  1  camera pixel clock; all logic on its rising edge.
- resetn  in  1  reset.
- vsync  in  1  camera vertical sync.
- href  in  1  camera line valid.
- data  in  DATA_W  camera data.
- ctrl_enable  in  1  capture enable; sampled only at frame start.
- err_clear  in  1  single-cycle pulse; clears sticky error flags.
- fsync  out  1  one-cycle frame-start pulse to VDMA.
- m_axis_tvalid  out  1  stream valid.
- m_axis_tready  in  1  stream ready.
- m_axis_tdata  out  TDATA_W  pixel, zero-extended; first camera byte in the MSB position.
- m_axis_tuser  out  1  start of frame (first pixel).
- m_axis_tlast  out  1  end of line (pixel H_SIZE-1).
- busy  out  1  state is ACTIVE or DROP.
- err_overflow  out  1  sticky: FIFO full when a pixel completed.
- err_short_line  out  1  sticky: href fell with fewer than H_SIZE pixels.
- err_long_line  out  1  sticky: more than H_SIZE pixels in a line; extras discarded.
- err_frame_size  out  1  sticky: frame ended with a line count other than V_SIZE.
- frame_count  out  16  frames fully delivered (see Optional Feature).
- drop_count  out  16  frames dropped (see Optional Feature).

Behaviour:
- Reset: resetn is synchronous and active-low; clock is pclk. All outputs are 0 at reset, the FIFO is emptied, and the state goes to IDLE. Reset mid-frame abandons the frame; no partial tlast is emitted.
- Blanking and edges: vs_blank = (vsync == VSYNC_POL). A frame starts on the blank->active transition, detected with a registered previous value. The frame ends on the active->blank transition.
- States:
  - IDLE: at frame start, if ctrl_enable=1, pulse fsync for one cycle and go to ACTIVE; otherwise stay in IDLE.
  - ACTIVE: capture pixels. At frame end, check the line count (!= V_SIZE -> err_frame_size), then go to IDLE.
  - DROP: ignore data until frame end, then go to IDLE.
  - A new frame is never entered mid-frame, so ctrl_enable changes take effect at the next frame start.
- Byte assembly (ACTIVE, href=1): a beat counter 0..BYTES_PER_PIX-1 captures data each cycle. The beat counter resets on href rising edge and in blanking. On the final beat the pixel is complete; the FIFO write happens on that same edge.
- Counters:
  - pix_cnt increments per completed pixel and resets on href rising edge.
  - line_cnt increments on each href falling edge within ACTIVE.
- Stream markers:
  - tuser is set on the pixel with line_cnt=0, pix_cnt=0.
  - tlast is set on pix_cnt=H_SIZE-1.
  - Pixels with pix_cnt >= H_SIZE are not written and set err_long_line.
- Short line: on href falling edge with 0 < pix_cnt < H_SIZE, set err_short_line. No padding is inserted and the line is not terminated with tlast.
- Overflow: if the FIFO is full when a pixel completes, drop that pixel, set err_overflow, increment drop_count, and go to DROP. Words already in the FIFO still drain.
- FIFO: synchronous with a registered output.
  - Latency: write at edge N -> tvalid high after edge N+1 when the FIFO was empty.
  - Simultaneous push and pop at full is permitted; occupancy is unchanged and it is not an overflow.
- AXIS rules: tdata, tuser and tlast hold stable while tvalid=1 and tready=0. Transfer occurs when tvalid & tready.
- Sticky errors: cleared by err_clear. If an error event coincides with err_clear, the flag ends up set.
- frame_count increments at frame end from ACTIVE only if no error occurred during that frame. Both counters wrap at 16 bits.

Optional Feature:
- CAPTURE_STATS_EN.
  - Defined: frame_count and drop_count are implemented as described.
  - Undefined: both ports are driven constant 0 and the counter logic is removed. All other behaviour is identical.

Test Plan:
- H_SIZE=4, V_SIZE=2, BYTES_PER_PIX=2, tready=1, ctrl_enable=1; bytes 0x12,0x34,... -> fsync pulse once, 8 beats. First tdata=0x00001234 with tuser=1. tlast on beats 4 and 8. No errors; frame_count=1.
- Same frame with ctrl_enable deasserted mid-frame -> frame completes normally. The next frame produces no fsync and no beats.
- tready=0 for the whole frame, FIFO_DEPTH=4 -> exactly 4 words are retained, err_overflow=1, drop_count=1. After tready=1, the 4 words drain with correct tuser/tlast, and the next frame is captured cleanly.
- Line 0 carries 3 pixels, then line 1 carries 5 pixels -> err_short_line=1 and err_long_line=1. The 5th pixel of line 1 is absent, and err_frame_size remains 0 (2 lines).
- resetn asserted mid-line -> tvalid=0 and all flags 0 on the next cycle. Capture resumes only after the next blank->active transition.
- err_clear pulsed on the same cycle as an overflow event -> err_overflow remains 1. A lone err_clear clears it.
